// File: rtl/decode_issue_queue.sv
// -----------------------------------------------------------------------------
// decode_issue_queue
//
// Purpose:
//    First-word-fall-through buffer between the decode-stage-2 mux and the
//    register-read/dispatch stage. Each decoded bundle is held until the
//    downstream stage takes it with a valid/ready handshake. The decode
//    pipeline cannot be back-pressured cycle by cycle. The queue therefore
//    raises an early stall while free entries remain for in-flight bundles.
//    A sticky flag records any bundle lost to overflow. A branch-resolution
//    flush empties the queue.
//
// Ports:
//    clock_i      rising-edge clock
//    reset_i      asynchronous active-low reset
//    enable_i     bundle valid from decode stage 2
//    instr_i      packed decoded-instruction bundle (opaque payload)
//    flush_i      synchronous discard of all entries
//    ready_i      downstream accepts the head entry this cycle
//    valid_o      head entry present
//    instr_o      head entry payload (meaningless while valid_o is low)
//    stall_o      front end must stop issuing bundles
//    count_o      current occupancy
//    overflow_o   sticky: a bundle was dropped because the queue was full
// -----------------------------------------------------------------------------
module decode_issue_queue #(
   parameter int depth        = 4,
   parameter int ptrWidth     = 2,
   parameter int stallMargin  = 2,
   parameter int payloadWidth = 130
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    enable_i,
   input  logic [payloadWidth-1:0] instr_i,
   input  logic                    flush_i,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic [payloadWidth-1:0] instr_o,
   output logic                    stall_o,
   output logic [ptrWidth:0]       count_o,
   output logic                    overflow_o
);

   localparam logic [ptrWidth:0] FullCount  = (ptrWidth+1)'(depth);
   localparam logic [ptrWidth:0] StallCount = (ptrWidth+1)'(depth - stallMargin);

   logic [payloadWidth-1:0] mem_q [depth];

   logic [ptrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [ptrWidth:0]   count_q,  count_d;
   logic                overflow_q, overflow_d;

   logic pop;
   logic push;
   logic wr_en;

   assign valid_o    = (count_q != '0);
   assign stall_o    = (count_q >= StallCount);
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign instr_o    = mem_q[rd_ptr_q];

   assign pop   = valid_o && ready_i;
   // A full queue still accepts a bundle when the head leaves in the same cycle.
   assign push  = enable_i && ((count_q != FullCount) || pop);
   assign wr_en = push && !flush_i;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush_i) begin
         // Same-cycle push/pop are discarded. The sticky error is kept.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (enable_i && !push) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset. Each entry has its own write decode.
   generate
      for (genvar gi = 0; gi < depth; gi++) begin : g_entry
         always_ff @(posedge clock_i) begin
            if (wr_en && (wr_ptr_q == ptrWidth'(gi))) begin
               mem_q[gi] <= instr_i;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_decode_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_queue
//
// Purpose:
//    Directed testbench for decode_issue_queue. Each scenario task drives its
//    own stimulus and checks the outputs against hand-computed values.
//    Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_decode_issue_queue;

   localparam int PW = 130;

   logic          clk;
   logic          reset_i;
   logic          enable_i;
   logic [PW-1:0] instr_i;
   logic          flush_i;
   logic          ready_i;
   logic          valid_o;
   logic [PW-1:0] instr_o;
   logic          stall_o;
   logic [2:0]    count_o;
   logic          overflow_o;

   int checks;
   int errors;

   decode_issue_queue #(
      .depth(4), .ptrWidth(2), .stallMargin(2), .payloadWidth(PW)
   ) dut (
      .clock_i   (clk),
      .reset_i   (reset_i),
      .enable_i  (enable_i),
      .instr_i   (instr_i),
      .flush_i   (flush_i),
      .ready_i   (ready_i),
      .valid_o   (valid_o),
      .instr_o   (instr_o),
      .stall_o   (stall_o),
      .count_o   (count_o),
      .overflow_o(overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle: address in the top 64 bits, format in the low 5 bits, and a
   // filler pattern in between so that the middle fields also get checked.
   function automatic logic [PW-1:0] mk(input logic [63:0] addr, input logic [4:0] fmt);
      logic [60:0] mid;
      mid = 61'(addr * 64'd3) ^ 61'h0A5A_5A5A_5A5A_5A5A;
      return {addr, mid, fmt};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      #3;
      reset_i = 1'b1;
      step();
   endtask

   task automatic push_one(input logic [63:0] addr);
      enable_i = 1'b1;
      instr_i  = mk(addr, 5'd3);
      step();
      enable_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      #3;
      checks++;
      if ((valid_o !== 1'b0) || (count_o !== 3'd0) || (stall_o !== 1'b0) || (overflow_o !== 1'b0)) begin
         errors++;
         $display("FAIL reset_state got v=%b c=%0d s=%b o=%b exp v=0 c=0 s=0 o=0",
                  valid_o, count_o, stall_o, overflow_o);
      end
      reset_i = 1'b1;
      step();
      $display("reset: v=%b c=%0d s=%b o=%b", valid_o, count_o, stall_o, overflow_o);
   endtask

   task automatic test_single_push();
      push_one(64'h1000);
      checks++;
      if ((valid_o !== 1'b1) || (instr_o !== mk(64'h1000, 5'd3)) || (count_o !== 3'd1) || (stall_o !== 1'b0)) begin
         errors++;
         $display("FAIL single_push got v=%b c=%0d s=%b instr=%h exp v=1 c=1 s=0 instr=%h",
                  valid_o, count_o, stall_o, instr_o, mk(64'h1000, 5'd3));
      end
      $display("single push: v=%b c=%0d addr=%h", valid_o, count_o, instr_o[PW-1 -: 64]);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      checks++;
      if ((valid_o !== 1'b0) || (count_o !== 3'd0)) begin
         errors++;
         $display("FAIL single_pop got v=%b c=%0d exp v=0 c=0", valid_o, count_o);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         push_one(64'h1000 + 64'(4 * i));
         checks++;
         if ((count_o !== 3'(i + 1)) || (stall_o !== ((i + 1) >= 2)) || (overflow_o !== 1'b0)) begin
            errors++;
            $display("FAIL fill_%0d got c=%0d s=%b o=%b exp c=%0d s=%b o=0",
                     i, count_o, stall_o, overflow_o, i + 1, ((i + 1) >= 2));
         end
         $display("fill %0d: c=%0d s=%b", i, count_o, stall_o);
      end
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((valid_o !== 1'b1) || (instr_o !== mk(64'h1000 + 64'(4 * i), 5'd3))) begin
            errors++;
            $display("FAIL drain_%0d got v=%b addr=%h exp v=1 addr=%h",
                     i, valid_o, instr_o[PW-1 -: 64], 64'h1000 + 64'(4 * i));
         end
         $display("drain %0d: addr=%h", i, instr_o[PW-1 -: 64]);
         step();
      end
      ready_i = 1'b0;
      checks++;
      if ((valid_o !== 1'b0) || (count_o !== 3'd0) || (stall_o !== 1'b0)) begin
         errors++;
         $display("FAIL drain_empty got v=%b c=%0d s=%b exp v=0 c=0 s=0", valid_o, count_o, stall_o);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) push_one(64'h1000 + 64'(4 * i));
      enable_i = 1'b1;
      instr_i  = mk(64'h2000, 5'd3);
      ready_i  = 1'b1;
      step();
      enable_i = 1'b0;
      checks++;
      if ((count_o !== 3'd4) || (instr_o !== mk(64'h1004, 5'd3)) || (overflow_o !== 1'b0)) begin
         errors++;
         $display("FAIL full_push_pop got c=%0d addr=%h o=%b exp c=4 addr=1004 o=0",
                  count_o, instr_o[PW-1 -: 64], overflow_o);
      end
      $display("full push+pop: c=%0d head=%h", count_o, instr_o[PW-1 -: 64]);
      for (int i = 0; i < 4; i++) begin
         logic [63:0] ea;
         ea = (i == 3) ? 64'h2000 : 64'h1004 + 64'(4 * i);
         checks++;
         if ((valid_o !== 1'b1) || (instr_o !== mk(ea, 5'd3))) begin
            errors++;
            $display("FAIL full_drain_%0d got v=%b addr=%h exp addr=%h", i, valid_o, instr_o[PW-1 -: 64], ea);
         end
         step();
      end
      ready_i = 1'b0;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) push_one(64'h1000 + 64'(4 * i));
      push_one(64'h5000);
      checks++;
      if ((overflow_o !== 1'b1) || (count_o !== 3'd4) || (instr_o !== mk(64'h1000, 5'd3))) begin
         errors++;
         $display("FAIL overflow got o=%b c=%0d head=%h exp o=1 c=4 head=1000",
                  overflow_o, count_o, instr_o[PW-1 -: 64]);
      end
      $display("overflow: o=%b c=%0d", overflow_o, count_o);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      checks++;
      if ((overflow_o !== 1'b1) || (count_o !== 3'd0) || (valid_o !== 1'b0)) begin
         errors++;
         $display("FAIL overflow_sticky got o=%b c=%0d v=%b exp o=1 c=0 v=0", overflow_o, count_o, valid_o);
      end
      do_reset();
      checks++;
      if (overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear got o=%b exp o=0", overflow_o);
      end
      $display("overflow after reset: o=%b", overflow_o);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push_one(64'h1000 + 64'(4 * i));
      checks++;
      if ((count_o !== 3'd3) || (stall_o !== 1'b1)) begin
         errors++;
         $display("FAIL flush_pre got c=%0d s=%b exp c=3 s=1", count_o, stall_o);
      end
      flush_i  = 1'b1;
      enable_i = 1'b1;
      instr_i  = mk(64'hDEAD, 5'd3);
      ready_i  = 1'b1;
      step();
      flush_i  = 1'b0;
      enable_i = 1'b0;
      ready_i  = 1'b0;
      checks++;
      if ((count_o !== 3'd0) || (valid_o !== 1'b0) || (stall_o !== 1'b0) || (overflow_o !== 1'b0)) begin
         errors++;
         $display("FAIL flush got c=%0d v=%b s=%b o=%b exp c=0 v=0 s=0 o=0",
                  count_o, valid_o, stall_o, overflow_o);
      end
      $display("flush: c=%0d v=%b", count_o, valid_o);
      push_one(64'h3000);
      checks++;
      if ((valid_o !== 1'b1) || (count_o !== 3'd1) || (instr_o !== mk(64'h3000, 5'd3))) begin
         errors++;
         $display("FAIL flush_repush got v=%b c=%0d addr=%h exp v=1 c=1 addr=3000",
                  valid_o, count_o, instr_o[PW-1 -: 64]);
      end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
   endtask

   task automatic test_wrap();
      push_one(64'h0);
      for (int i = 1; i < 10; i++) begin
         enable_i = 1'b1;
         instr_i  = mk(64'(4 * i), 5'd3);
         ready_i  = 1'b1;
         checks++;
         if ((valid_o !== 1'b1) || (instr_o !== mk(64'(4 * (i - 1)), 5'd3))) begin
            errors++;
            $display("FAIL wrap_%0d got v=%b addr=%h exp addr=%h",
                     i, valid_o, instr_o[PW-1 -: 64], 64'(4 * (i - 1)));
         end
         $display("wrap %0d: head=%h", i, instr_o[PW-1 -: 64]);
         step();
         checks++;
         if (count_o !== 3'd1) begin
            errors++;
            $display("FAIL wrap_count_%0d got c=%0d exp c=1", i, count_o);
         end
      end
      enable_i = 1'b0;
      checks++;
      if (instr_o !== mk(64'h24, 5'd3)) begin
         errors++;
         $display("FAIL wrap_last got addr=%h exp addr=24", instr_o[PW-1 -: 64]);
      end
      step();
      ready_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_empty got v=%b exp v=0", valid_o);
      end
   endtask

   task automatic test_async_reset();
      push_one(64'h4000);
      push_one(64'h4004);
      checks++;
      if ((count_o !== 3'd2) || (stall_o !== 1'b1)) begin
         errors++;
         $display("FAIL async_pre got c=%0d s=%b exp c=2 s=1", count_o, stall_o);
      end
      #2;
      reset_i = 1'b0;
      #1;
      checks++;
      if ((valid_o !== 1'b0) || (count_o !== 3'd0) || (stall_o !== 1'b0)) begin
         errors++;
         $display("FAIL async_reset got v=%b c=%0d s=%b exp v=0 c=0 s=0", valid_o, count_o, stall_o);
      end
      $display("async reset: v=%b c=%0d s=%b", valid_o, count_o, stall_o);
      #3;
      reset_i = 1'b1;
      step();
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset_i  = 1'b1;
      enable_i = 1'b0;
      instr_i  = '0;
      flush_i  = 1'b0;
      ready_i  = 1'b0;
      #2;
      test_reset();
      test_single_push();
      test_fill_drain();
      test_full_push_pop();
      test_overflow();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Buffer between the decode-stage-2 multiplexer and the register-read/dispatch stage.
- Captures each muxed decoded-instruction bundle in a small first-word-fall-through (FWFT) FIFO and presents it to the downstream stage with a valid/ready handshake.
- The decode pipeline has no per-cycle backpressure. The queue therefore raises an early stall to the fetch/decode front end and flags any bundle lost to overflow.
- Supports a pipeline flush from branch resolution.

Parameters:
- depth, 4, number of entries; power of two, >= 4.
- ptrWidth, 2, log2(depth).
- stallMargin, 2, free entries reserved to absorb in-flight decode bundles after stall_o rises.
- payloadWidth, 130, width of the packed instruction bundle.

Ports:
- clock_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  bundle valid from decode stage 2 (its enable_o).
- instr_i  in  payloadWidth  packed bundle, MSB-first in this order:
  - instructionAddress[64], opcode[6], xOpcode[10], xOpcodeEnable[1]
  - imm[16], immEnable[1], reg1/reg2/reg3[5 each], reg1/2/3Enable[3]
  - reg3IsImmediate[1], bit1/bit2[2], bit1/2Enable[2], reg2ValOrZero[1]
  - functionalUnitCode[3], instructionFormat[5]
- flush_i  in  1  synchronous discard of all entries.
- ready_i  in  1  downstream accepts the head entry this cycle.
- valid_o  out  1  head entry present.
- instr_o  out  payloadWidth  head entry payload.
- stall_o  out  1  front end must stop issuing new bundles.
- count_o  out  ptrWidth+1  current occupancy.
- overflow_o  out  1  sticky error: a bundle was dropped.

Behaviour:
Reset (reset_i low, asynchronous, takes effect immediately and overrides everything including mid-transfer):
- Read and write pointers = 0; count = 0.
- overflow_o = 0; valid_o = 0; stall_o = 0.
- Storage array is not reset.
- instr_o is don't-care while valid_o = 0; the bench must not check it then.

Handshake signals:
- pop = valid_o && ready_i.
- push = enable_i && (count < depth || pop).
- A push into a full queue is accepted only if a pop occurs in the same cycle.

Normal cycle (flush_i low):
- On push: mem[wrPtr] <= instr_i; wrPtr <= wrPtr + 1, wrapping modulo depth.
- On pop: rdPtr <= rdPtr + 1, wrapping modulo depth.
- count <= count + push - pop.

FWFT output:
- valid_o = (count != 0).
- instr_o = mem[rdPtr], combinational from the registered array.
- A bundle pushed at edge N is visible on instr_o with valid_o = 1 after edge N. Latency is one cycle.
- Push and pop in the same cycle when empty is impossible, since valid_o = 0.
- Push and pop in the same cycle otherwise: count unchanged, both pointers advance.

Stall:
- stall_o = (count >= depth - stallMargin), combinational from the registered count.
- With depth 4, stall_o asserts at count 2.
- It deasserts the cycle after a pop brings count below the threshold.

Overflow:
- If enable_i = 1, count = depth and no pop, the bundle is dropped and overflow_o <= 1.
- overflow_o holds until reset; flush_i does not clear it.
- Pointers and count are unchanged on a drop.

Flush (flush_i high at a rising edge):
- Pointers <= 0, count <= 0.
- A same-cycle push and pop are both ignored; ready_i has no effect.
- A same-cycle push never sets overflow_o.
- valid_o = 0 from the next cycle.

Ordering:
- Strict FIFO order.
- Payload bits pass through unmodified; the queue interprets no field.

Test Plan:
- Reset then single push: enable_i=1 with instructionAddress=0x1000, instructionFormat=3, ready_i=0 → after the edge valid_o=1, instr_o equals the pushed bundle, count_o=1, stall_o=0.
- Fill: 4 consecutive pushes with addresses 0x1000/0x1004/0x1008/0x100C, ready_i=0 → stall_o rises once count_o=2, count_o reaches 4, overflow_o stays 0. Then ready_i=1 for 4 cycles → addresses drain in order 0x1000…0x100C, then valid_o=0.
- Full with simultaneous push and pop: count_o=4, enable_i=1 (address 0x2000), ready_i=1 → count_o stays 4, the head advances, 0x2000 emerges last, overflow_o=0.
- Overflow: count_o=4, enable_i=1, ready_i=0 → bundle dropped, overflow_o=1, count_o=4. overflow_o remains 1 after a flush and clears only on reset.
- Flush: count_o=3, flush_i=1 with enable_i=1 and ready_i=1 → next cycle count_o=0, valid_o=0, stall_o=0. A subsequent push of 0x3000 appears at the head.
- Wrap-around and asynchronous reset: 10 push/pop pairs with addresses 0x0..0x24 step 4 → FIFO order preserved across pointer wrap. Assert reset_i low mid-clock with count_o=2 → valid_o, count_o and stall_o drop to 0 immediately, without waiting for an edge.
